// File: rtl/mem_io_responder.sv
// Purpose : memory-side responder for the CPU byte bus: 128 KB sync RAM plus an I/O window
//           (UART TX FIFO, input port, cycle counter with snapshot, program-stop latch).
// Latency : reads return on mem_din one cycle after the sampling edge; writes land at the edge.
// Backpressure: io_buffer_full rises one slot before the FIFO is full; pushes into a full
//           FIFO with no simultaneous pop are dropped and latch tx_overflow.
//
// Ports:
//   clk_in, rst_in            clock (rising edge), asynchronous active-high reset
//   mem_a, mem_wr, mem_dout   CPU bus: address (bits 17:0 decoded), write strobe, write data
//   mem_din, io_buffer_full   registered read data and UART nearly-full flag back to the CPU
//   tx_valid, tx_data, tx_ready   FIFO head towards the UART sink (valid/ready handshake)
//   in_valid, in_data, in_ack     input byte port; in_ack pulses when a byte is consumed
//   halt, tx_overflow             sticky program-stop and dropped-push flags
module mem_io_responder #(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ack,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] NEARLY_C  = CW'(FIFO_DEPTH - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel_io;
    logic       sel_ram;
    logic [2:0] io_off;
    logic       rd_cyc;
    logic       wr_cyc;

    assign sel_io  = (mem_a[17:16] == 2'b11);
    assign sel_ram = !sel_io && !mem_a[17];
    assign io_off  = mem_a[2:0];
    assign rd_cyc  = !mem_wr;
    assign wr_cyc  = mem_wr;

    // Upper address bits are outside the decoded range.
    logic unused_addr;
    assign unused_addr = ^mem_a[31:18];

    // ------------------------------------------------------------------
    // Byte RAM: kept in its own reset-free process so it maps onto block RAM.
    // The read register only loads on RAM reads, which gives the "hold on
    // write cycles" behaviour for free.
    // ------------------------------------------------------------------
    logic [7:0] ram_mem [2**RAM_AW];
    logic [7:0] ram_rd_q;

    always_ff @(posedge clk_in) begin
        if (wr_cyc && sel_ram) begin
            ram_mem[mem_a[RAM_AW-1:0]] <= mem_dout;
        end
        if (rd_cyc && sel_ram) begin
            ram_rd_q <= ram_mem[mem_a[RAM_AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter and its snapshot. Byte 0 of the snapshot is
    // returned live at the 0x30004 read, so only bytes 1..3 are stored.
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt_q;
    logic [23:0] snap_q;
    logic [23:0] snap_d;

    always_comb begin
        snap_d = snap_q;
        if (rd_cyc && sel_io && io_off == 3'd4) begin
            snap_d = cycle_cnt_q[31:8];
        end
    end

    // ------------------------------------------------------------------
    // I/O read mux
    // ------------------------------------------------------------------
    logic [7:0] io_rdat;
    logic       in_take;

    always_comb begin
        io_rdat = 8'h00;
        in_take = 1'b0;
        if (sel_io) begin
            case (io_off)
                3'd0: begin
                    if (in_valid) begin
                        io_rdat = in_data;
                        in_take = rd_cyc;
                    end
                end
                3'd4:    io_rdat = cycle_cnt_q[7:0];
                3'd5:    io_rdat = snap_q[7:0];
                3'd6:    io_rdat = snap_q[15:8];
                3'd7:    io_rdat = snap_q[23:16];
                default: io_rdat = 8'h00;
            endcase
        end
    end

    // mem_din is selected between two registers: the RAM read register and
    // the I/O/unmapped read register. The select itself is registered on the
    // read edge, so the output only changes right after a read edge.
    logic       rd_src_ram_q;
    logic       rd_src_ram_d;
    logic [7:0] io_rd_q;
    logic [7:0] io_rd_d;
    logic       in_ack_q;
    logic       in_ack_d;

    always_comb begin
        rd_src_ram_d = rd_src_ram_q;
        io_rd_d      = io_rd_q;
        in_ack_d     = in_take;
        if (rd_cyc) begin
            rd_src_ram_d = sel_ram;
            // Unmapped space (0x20000-0x2FFFF) leaves io_rdat at zero.
            io_rd_d      = sel_ram ? 8'h00 : io_rdat;
        end
    end

    assign mem_din = rd_src_ram_q ? ram_rd_q : io_rd_q;
    assign in_ack  = in_ack_q;

    // ------------------------------------------------------------------
    // I/O writes: UART push and halt
    // ------------------------------------------------------------------
    logic       halt_q;
    logic       halt_d;
    logic       io_wr_live;
    logic       push_req;
    logic [7:0] push_dat;

    assign io_wr_live = wr_cyc && sel_io && !halt_q;
    // The halt write pushes a 0x00 terminator; ordinary zero bytes are filtered.
    assign push_req   = io_wr_live &&
                        ((io_off == 3'd0 && mem_dout != 8'h00) || io_off == 3'd4);
    assign push_dat   = (io_off == 3'd4) ? 8'h00 : mem_dout;

    always_comb begin
        halt_d = halt_q;
        if (io_wr_live && io_off == 3'd4) begin
            halt_d = 1'b1;
        end
    end

    assign halt = halt_q;

    // ------------------------------------------------------------------
    // UART TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pop;
    logic          push_ok;
    logic          ibf_q;
    logic          ibf_d;
    logic          ovf_q;
    logic          ovf_d;

    assign tx_valid = (count_q != '0);
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        // One slot of slack: the CPU may still issue one write in the cycle
        // this flag rises.
        ibf_d = (count_d >= NEARLY_C);
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_dat;
        end
    end

    assign io_buffer_full = ibf_q;
    assign tx_overflow    = ovf_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt_q  <= '0;
            snap_q       <= '0;
            rd_src_ram_q <= 1'b0;
            io_rd_q      <= 8'h00;
            in_ack_q     <= 1'b0;
            halt_q       <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ibf_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_q + 32'd1;
            snap_q       <= snap_d;
            rd_src_ram_q <= rd_src_ram_d;
            io_rd_q      <= io_rd_d;
            in_ack_q     <= in_ack_d;
            halt_q       <= halt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ibf_q        <= ibf_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ack;
    logic        halt;
    logic        tx_overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0]  txq [$];
    logic        ibf_seen;
    logic [31:0] ecnt;

    mem_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ack         (in_ack),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Expected cycle counter value: cycles elapsed since reset release.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) ecnt <= 32'd0;
        else        ecnt <= ecnt + 32'd1;
    end

    // UART sink: handshake signals are stable from posedge+1 to the next
    // posedge, so sampling at the falling edge sees the values that pop.
    always @(negedge clk_in) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
        if (io_buffer_full === 1'b1) ibf_seen = 1'b1;
    end

    // One bus transaction; returns 1 time unit after the sampling edge.
    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'h0001_FFF0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        #12;
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_ibf got=%b exp=0", io_buffer_full); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_in_ack got=%b exp=0", in_ack); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_tx_overflow got=%b exp=0", tx_overflow); end
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic test_ram;
        bus(32'h0000_0010, 1'b1, 8'hA5);
        bus(32'h0000_0010, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_read got=%h exp=a5", mem_din); end
        // Write cycle must hold the previous read data.
        bus(32'h0000_0020, 1'b1, 8'h3C);
        total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_hold_on_write got=%h exp=a5", mem_din); end
        bus(32'h0001_FFFF, 1'b1, 8'h5A);
        bus(32'h0001_FFFF, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h5A) begin bad++; $display("FAIL ram_top_byte got=%h exp=5a", mem_din); end
        bus(32'h0000_0000, 1'b1, 8'h11);
        bus(32'h0002_0000, 1'b1, 8'hFF);
        bus(32'h0002_0000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%h exp=00", mem_din); end
        bus(32'h0000_0000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h11) begin bad++; $display("FAIL unmapped_write_ignored got=%h exp=11", mem_din); end
        bus(32'h0000_0020, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h3C) begin bad++; $display("FAIL ram_read2 got=%h exp=3c", mem_din); end
    endtask

    task automatic test_uart;
        tx_ready = 1'b1;
        txq.delete();
        ibf_seen = 1'b0;
        bus(32'h0003_0000, 1'b1, 8'h48);
        bus(32'h0003_0000, 1'b1, 8'h00);
        bus(32'h0003_0000, 1'b1, 8'h69);
        idle(4);
        total++; if (txq.size() != 2) begin bad++; $display("FAIL uart_count got=%0d exp=2", txq.size()); end
        else begin
            total++; if (txq[0] !== 8'h48) begin bad++; $display("FAIL uart_byte0 got=%h exp=48", txq[0]); end
            total++; if (txq[1] !== 8'h69) begin bad++; $display("FAIL uart_byte1 got=%h exp=69", txq[1]); end
        end
        total++; if (ibf_seen !== 1'b0) begin bad++; $display("FAIL uart_ibf_stays_low got=%b exp=0", ibf_seen); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL uart_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_backpressure;
        tx_ready = 1'b0;
        txq.delete();
        for (int i = 1; i <= 6; i++) begin
            bus(32'h0003_0000, 1'b1, 8'(i));
            if (i == 1) begin
                total++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
                    bad++; $display("FAIL bp_head got=%b/%h exp=1/01", tx_valid, tx_data); end
            end
        end
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL bp_ibf_after6 got=%b exp=0", io_buffer_full); end
        bus(32'h0003_0000, 1'b1, 8'h07);
        total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL bp_ibf_after7 got=%b exp=1", io_buffer_full); end
        bus(32'h0003_0000, 1'b1, 8'h08);
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL bp_8th_accepted got=%b exp=0", tx_overflow); end
        bus(32'h0003_0000, 1'b1, 8'h09);
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL bp_9th_dropped got=%b exp=1", tx_overflow); end
        tx_ready = 1'b1;
        idle(12);
        total++; if (txq.size() != 8) begin bad++; $display("FAIL bp_drain_count got=%0d exp=8", txq.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (txq[i] !== 8'(i + 1)) begin
                    bad++; $display("FAIL bp_drain_order idx=%0d got=%h exp=%h", i, txq[i], 8'(i + 1)); end
            end
        end
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL bp_ibf_after_drain got=%b exp=0", io_buffer_full); end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_sticky got=%b exp=1", tx_overflow); end
    endtask

    task automatic test_timer;
        logic [31:0] snap;
        int n;
        idle(100);
        // Snapshot just below a byte-0 rollover so a live read of byte 1 would differ.
        n = 0;
        while (ecnt[7:0] != 8'hFE && n < 300) begin idle(1); n++; end
        total++; if (ecnt[7:0] != 8'hFE) begin bad++; $display("FAIL timer_align got=%h exp=fe", ecnt[7:0]); end
        snap = ecnt;
        bus(32'h0003_0004, 1'b0, 8'h00);
        total++; if (mem_din !== snap[7:0]) begin bad++; $display("FAIL timer_b0 got=%h exp=%h", mem_din, snap[7:0]); end
        bus(32'h0003_0005, 1'b0, 8'h00);
        total++; if (mem_din !== snap[15:8]) begin bad++; $display("FAIL timer_b1 got=%h exp=%h", mem_din, snap[15:8]); end
        bus(32'h0003_0006, 1'b0, 8'h00);
        total++; if (mem_din !== snap[23:16]) begin bad++; $display("FAIL timer_b2 got=%h exp=%h", mem_din, snap[23:16]); end
        bus(32'h0003_0007, 1'b0, 8'h00);
        total++; if (mem_din !== snap[31:24]) begin bad++; $display("FAIL timer_b3 got=%h exp=%h", mem_din, snap[31:24]); end
        idle(5);
        bus(32'h0003_0005, 1'b0, 8'h00);
        total++; if (mem_din !== snap[15:8]) begin bad++; $display("FAIL timer_b1_stable got=%h exp=%h", mem_din, snap[15:8]); end
        bus(32'h0003_0003, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL io_other_read got=%h exp=00", mem_din); end
    endtask

    task automatic test_stop;
        tx_ready = 1'b1;
        txq.delete();
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL stop_pre got=%b exp=0", halt); end
        bus(32'h0003_0004, 1'b1, 8'h55);
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL stop_halt got=%b exp=1", halt); end
        idle(3);
        total++; if (txq.size() != 1) begin bad++; $display("FAIL stop_marker_count got=%0d exp=1", txq.size()); end
        else begin
            total++; if (txq[0] !== 8'h00) begin bad++; $display("FAIL stop_marker got=%h exp=00", txq[0]); end
        end
        bus(32'h0003_0000, 1'b1, 8'h41);
        idle(3);
        total++; if (txq.size() != 1) begin bad++; $display("FAIL stop_blocks_push got=%0d exp=1", txq.size()); end
        bus(32'h0000_0040, 1'b1, 8'h77);
        bus(32'h0000_0040, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h77) begin bad++; $display("FAIL stop_ram_write got=%h exp=77", mem_din); end
    endtask

    task automatic test_input;
        in_valid = 1'b1;
        in_data  = 8'h37;
        bus(32'h0003_0000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h37) begin bad++; $display("FAIL input_data got=%h exp=37", mem_din); end
        total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL input_ack got=%b exp=1", in_ack); end
        in_valid = 1'b0;
        idle(1);
        total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL input_ack_pulse got=%b exp=0", in_ack); end
        bus(32'h0003_0000, 1'b0, 8'h00);
        total++; if (mem_din !== 8'h00 || in_ack !== 1'b0) begin
            bad++; $display("FAIL input_none got=%h/%b exp=00/0", mem_din, in_ack); end
    endtask

    task automatic test_reset_mid;
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        total++; if (halt !== 1'b0 || tx_overflow !== 1'b0) begin
            bad++; $display("FAIL rst_flags got=%b/%b exp=0/0", halt, tx_overflow); end
        tx_ready = 1'b0;
        bus(32'h0003_0000, 1'b1, 8'hC1);
        bus(32'h0003_0000, 1'b1, 8'hC2);
        bus(32'h0003_0000, 1'b1, 8'hC3);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rst_prefill got=%b exp=1", tx_valid); end
        #2;
        rst_in = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_async_tx_valid got=%b exp=0", tx_valid); end
        rst_in = 1'b0;
        txq.delete();
        tx_ready = 1'b1;
        bus(32'h0000_0010, 1'b0, 8'h00);
        idle(2);
        total++; if (txq.size() != 0) begin bad++; $display("FAIL rst_fifo_flushed got=%0d exp=0", txq.size()); end
        bus(32'h0000_0010, 1'b0, 8'h00);
        total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL rst_ram_kept got=%h exp=a5", mem_din); end
    endtask

    initial begin
        rst_in   = 1'b1;
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ibf_seen = 1'b0;
        test_reset();
        test_ram();
        test_uart();
        test_backpressure();
        test_timer();
        test_stop();
        test_input();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide RAM/IO bus: the RAM, UART and timer end of the interface that the CPU's memory controller drives through mem_a/mem_wr/mem_dout and samples via mem_din/io_buffer_full. It holds a 128 KB synchronous byte RAM and decodes the I/O window at mem_a[17:16]==2'b11. Behind that window sit a UART transmit FIFO with a back-pressure flag, a byte input port, a free-running cycle counter and a program-stop latch. It is used in simulation and on the FPGA top.

## Interface
- RAM_AW, 17: RAM address width (2^17 bytes).
- FIFO_DEPTH, 8: UART TX FIFO entries, power of two, at least 4.
- clk_in  in  1  system clock, rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- mem_a  in  32  CPU address bus; only bits 17:0 are decoded.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  in  8  CPU write data.
- mem_din  out  8  read data to the CPU, registered.
- io_buffer_full  out  1  UART FIFO nearly full, registered.
- tx_valid  out  1  FIFO head is valid.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  UART sink accepts the head this cycle.
- in_valid  in  1  input byte available.
- in_data  in  8  input byte.
- in_ack  out  1  one-cycle pulse: input byte consumed.
- halt  out  1  sticky program-stop flag.
- tx_overflow  out  1  sticky flag: a push was dropped because the FIFO was full.

## Operation
- **Bus transaction.** Every rising edge is one bus transaction; there is no idle encoding.
- **Decode:**
  - io = (mem_a[17:16]==2'b11).
  - ram = !io && mem_a[17]==0; RAM index is mem_a[16:0].
  - Any other address (0x20000–0x2FFFF) reads as 0x00, and writes to it are ignored.
- **RAM:**
  - Write stores mem_dout.
  - Read returns the stored byte.
  - Contents are not cleared by reset.
- **I/O read, by mem_a[2:0] within the window:**
  - 0x30000: if in_valid, return in_data and pulse in_ack; otherwise return 0x00.
  - 0x30004: return cycle_cnt[7:0] and latch snap <= cycle_cnt.
  - 0x30005, 0x30006, 0x30007: return snap[15:8], snap[23:16], snap[31:24].
  - Any other I/O address: 0x00.
- **I/O write:**
  - 0x30000 with mem_dout != 0: push mem_dout. 0x00 is ignored.
  - 0x30004: set halt and push 0x00 (end-of-output marker), bypassing the zero filter.
  - After halt, all I/O writes are ignored; RAM writes continue.
- **FIFO:**
  - Circular buffer with rd_ptr, wr_ptr and count (log2(FIFO_DEPTH)+1 bits); pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when tx_valid && tx_ready.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and tx_overflow is set.
  - Simultaneous push and pop: count is unchanged.
  - tx_valid = (count != 0); tx_data = buf[rd_ptr].
- **io_buffer_full** is registered as (next count >= FIFO_DEPTH-1). This one-slot slack absorbs a CPU write issued in the cycle the flag rises.
- **cycle_cnt** is 32 bits, increments every cycle after reset and wraps 0xFFFFFFFF→0.

## Timing
- Read latency is 1 cycle: address sampled at edge N, mem_din valid after edge N and held until edge N+1. mem_din is updated on every read. On a write cycle it holds its previous value.
- Write takes effect at the sampling edge. A read of the same address at edge N+1 returns the new byte.
- in_ack is high for the one cycle following the sampling edge, aligned with mem_din.
- A pushed byte is visible on tx_valid/tx_data one cycle after the write edge.
- halt rises one cycle after the 0x30004 write edge.
- Reset values: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=don't care (no X propagation to tx_valid), in_ack=0, halt=0, tx_overflow=0, cycle_cnt=0, snap=0, count=0, pointers=0.
- Reset asserted mid-operation discards FIFO contents and clears all flags immediately (asynchronous). RAM is untouched.

## Test plan
- RAM write/readback: write 0xA5 @0x00010, then read 0x00010 → mem_din=0xA5 one cycle after the read edge. Read 0x20000 → 0x00.
- UART output: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 → tx_data sequence 0x48, 0x69 only; io_buffer_full stays 0.
- Back-pressure: tx_ready=0, push 7 bytes with FIFO_DEPTH=8 → io_buffer_full=1 after the 7th push. 8th push accepted, 9th dropped with tx_overflow=1. Then tx_ready=1 drains the first 8 bytes in order.
- Timer: run 100 cycles, read 0x30004..0x30007 on consecutive cycles → the bytes assemble the snapshot value at the 0x30004 read edge, unaffected by later increments.
- Stop: write 0x30004 → halt=1 next cycle and 0x00 emitted on tx. A later write of 0x41 to 0x30000 → no push.
- Input and reset: in_valid=1, in_data=0x37, read 0x30000 → mem_din=0x37 with a one-cycle in_ack. Assert rst_in with FIFO holding 3 bytes → tx_valid=0, count=0 immediately; RAM byte @0x00010 is still 0xA5.
